// File: rtl/rsa_modexp_core.sv
// Montgomery modular-exponentiation engine: C = M^E mod P using a bit-serial
// Montgomery multiplier, with start/stop control and busy/done/eoc/err status.
module rsa_modexp_core #(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WIDTH-1:0]     P,
    input  logic [EXP_WIDTH-1:0] E,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Const,
    output logic [WIDTH-1:0]     C,
    output logic                 busy,
    output logic                 done,
    output logic                 eoc,
    output logic                 err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int UW = WIDTH + 2;

    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [UW-1:0]    U_ZERO   = {UW{1'b0}};
    localparam logic [CW-1:0]    CYC_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CYC_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_CYC = CW'(WIDTH);
    localparam logic [IW-1:0]    IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0]    IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]    TOP_IDX  = IW'(EXP_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MUL, S_DONE} state_e;
    typedef enum logic [2:0] {PH_MBAR, PH_XINIT, PH_SQ, PH_MULT, PH_FINAL} phase_e;

    typedef struct packed {
        state_e               state;
        phase_e               phase;
        logic [WIDTH-1:0]     p;
        logic [EXP_WIDTH-1:0] e;
        logic [WIDTH-1:0]     m;
        logic [WIDTH-1:0]     k;
        logic [WIDTH-1:0]     mbar;
        logic [WIDTH-1:0]     a;
        logic [WIDTH-1:0]     b;
        logic [UW-1:0]        u;
        logic [CW-1:0]        cyc;
        logic [IW-1:0]        idx;
        logic [WIDTH-1:0]     res;
        logic [WIDTH-1:0]     c;
        logic                 busy;
        logic                 done;
        logic                 eoc;
        logic                 err;
    } core_t;

    localparam core_t CORE_RST = core_t'({$bits(core_t){1'b0}});

    core_t            core_q;
    core_t            core_d;
    logic [UW-1:0]    p_ext_s;
    logic [UW-1:0]    u_add_s;
    logic [UW-1:0]    u_odd_s;
    logic [WIDTH-1:0] mm_res_s;

    // One Montgomery step: add a[i]*b, make even by adding P, halve; plus final correction.
    assign p_ext_s  = {2'b00, core_q.p};
    assign u_add_s  = core_q.u + (core_q.a[0] ? {2'b00, core_q.b} : U_ZERO);
    assign u_odd_s  = u_add_s + (u_add_s[0] ? p_ext_s : U_ZERO);
    assign mm_res_s = (core_q.u >= p_ext_s) ? WIDTH'(core_q.u - p_ext_s) : core_q.u[WIDTH-1:0];

    // Next-state logic for the control FSM and the multiply sequencer.
    always_comb begin
        core_d = core_q;
        case (core_q.state)
            S_IDLE: begin
                if (start && !stop) begin
                    core_d.p     = P;
                    core_d.e     = E;
                    core_d.m     = M;
                    core_d.k     = Const;
                    core_d.eoc   = 1'b0;
                    core_d.err   = 1'b0;
                    core_d.state = S_LOAD;
                end else begin
                    core_d.state = S_IDLE;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    core_d.state = S_IDLE;
                end else if (!core_q.p[0]) begin
                    core_d.err   = 1'b1;
                    core_d.state = S_DONE;
                end else begin
                    core_d.state = S_MUL;
                    core_d.phase = PH_MBAR;
                    core_d.a     = core_q.m;
                    core_d.b     = core_q.k;
                    core_d.u     = U_ZERO;
                    core_d.cyc   = CYC_ZERO;
                end
            end
            S_MUL: begin
                if (stop) begin
                    core_d.state = S_IDLE;
                end else if (core_q.cyc != LAST_CYC) begin
                    core_d.u   = u_odd_s >> 1;
                    core_d.a   = core_q.a >> 1;
                    core_d.cyc = core_q.cyc + CYC_ONE;
                end else begin
                    // Correction cycle: retire this product and launch the next one.
                    core_d.u   = U_ZERO;
                    core_d.cyc = CYC_ZERO;
                    case (core_q.phase)
                        PH_MBAR: begin
                            core_d.mbar  = mm_res_s;
                            core_d.a     = ONE_W;
                            core_d.b     = core_q.k;
                            core_d.phase = PH_XINIT;
                        end
                        PH_XINIT: begin
                            core_d.a     = mm_res_s;
                            core_d.b     = mm_res_s;
                            core_d.idx   = TOP_IDX;
                            core_d.phase = PH_SQ;
                        end
                        PH_SQ: begin
                            core_d.a = mm_res_s;
                            if (core_q.e[core_q.idx]) begin
                                core_d.b     = core_q.mbar;
                                core_d.phase = PH_MULT;
                            end else if (core_q.idx == IDX_ZERO) begin
                                core_d.b     = ONE_W;
                                core_d.phase = PH_FINAL;
                            end else begin
                                core_d.b     = mm_res_s;
                                core_d.idx   = core_q.idx - IDX_ONE;
                                core_d.phase = PH_SQ;
                            end
                        end
                        PH_MULT: begin
                            core_d.a = mm_res_s;
                            if (core_q.idx == IDX_ZERO) begin
                                core_d.b     = ONE_W;
                                core_d.phase = PH_FINAL;
                            end else begin
                                core_d.b     = mm_res_s;
                                core_d.idx   = core_q.idx - IDX_ONE;
                                core_d.phase = PH_SQ;
                            end
                        end
                        PH_FINAL: begin
                            core_d.res   = mm_res_s;
                            core_d.phase = PH_MBAR;
                            core_d.state = S_DONE;
                        end
                        default: begin
                            core_d.state = S_IDLE;
                        end
                    endcase
                end
            end
            S_DONE: begin
                core_d.state = S_IDLE;
                core_d.eoc   = 1'b1;
                if (!core_q.err) begin
                    core_d.c = core_q.res;
                end else begin
                    core_d.c = core_q.c;
                end
            end
            default: begin
                core_d.state = S_IDLE;
            end
        endcase
        core_d.busy = (core_d.state != S_IDLE);
        core_d.done = (core_d.state == S_DONE);
    end

    // State register; ena freezes everything, clear acts as a synchronous reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            core_q <= CORE_RST;
        end else if (ena) begin
            if (clear) begin
                core_q <= CORE_RST;
            end else begin
                core_q <= core_d;
            end
        end
    end

    assign C    = core_q.c;
    assign busy = core_q.busy;
    assign done = core_q.done;
    assign eoc  = core_q.eoc;
    assign err  = core_q.err;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Scoreboard bench for rsa_modexp_core: directed 8-bit scenarios plus a random
// 16-bit sweep, each checked against a plain-arithmetic modexp reference.
module tb_rsa_modexp_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    logic        rstb8, ena8, clear8, start8, stop8;
    logic [7:0]  p8, e8, m8, k8, c8;
    logic        busy8, done8, eoc8, err8;
    logic        rstb16, ena16, clear16, start16, stop16;
    logic [15:0] p16, e16, m16, k16, c16;
    logic        busy16, done16, eoc16, err16;

    rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk(clk), .rstb(rstb8), .ena(ena8), .clear(clear8), .start(start8), .stop(stop8),
        .P(p8), .E(e8), .M(m8), .Const(k8), .C(c8),
        .busy(busy8), .done(done8), .eoc(eoc8), .err(err8));

    rsa_modexp_core #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
        .clk(clk), .rstb(rstb16), .ena(ena16), .clear(clear16), .start(start16), .stop(stop16),
        .P(p16), .E(e16), .M(m16), .Const(k16), .C(c16),
        .busy(busy16), .done(done16), .eoc(eoc16), .err(err16));

    typedef struct {
        logic [15:0] c;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t   q8[$];
    exp_t   q16[$];
    exp_t   pe8, pe16;
    bit     pend8 = 1'b0, pend16 = 1'b0, pdone8 = 1'b0, pdone16 = 1'b0;
    longint last_c8 = 0, last_c16 = 0;
    int     vectors = 0;
    int     miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cnt);
        end
    endtask

    function automatic longint ref_modexp(longint m, longint e, longint p, int w);
        longint r, b;
        r = 1 % p;
        b = m % p;
        for (int i = 0; i < w; i++) begin
            if (((e >> i) & 1) == 1) r = (r * b) % p;
            b = (b * b) % p;
        end
        return r;
    endfunction

    // Issue one start pulse; when push is set, queue the reference expectation.
    task automatic run(input bit w16, input logic [15:0] p, m, k, e, input bit push, input int stall);
        exp_t x;
        int   w;
        w = w16 ? 16 : 8;
        if (w16) begin
            p16 = p; m16 = m; k16 = k; e16 = e; start16 = 1'b1;
        end else begin
            p8 = p[7:0]; m8 = m[7:0]; k8 = k[7:0]; e8 = e[7:0]; start8 = 1'b1;
        end
        if (push) begin
            x.err = ~p[0];
            if (p[0]) begin
                x.c   = 16'(ref_modexp(longint'(m), longint'(e), longint'(p), w));
                x.cyc = cnt + (3 + w + $countones(e)) * (w + 1) + 2 + stall;
            end else begin
                x.c   = w16 ? 16'(last_c16) : 16'(last_c8);
                x.cyc = cnt + 2 + stall;
            end
            if (w16) begin
                last_c16 = longint'(x.c);
                q16.push_back(x);
            end else begin
                last_c8 = longint'(x.c);
                q8.push_back(x);
            end
        end
        @(negedge clk);
        if (w16) begin
            start16 = 1'b0;
            check("busy16_cycle1", busy16, 1);
            check("eoc16_cleared_on_start", eoc16, 0);
        end else begin
            start8 = 1'b0;
            check("busy8_cycle1", busy8, 1);
            check("eoc8_cleared_on_start", eoc8, 0);
        end
    endtask

    task automatic wait_idle(input bit w16, input int budget);
        int n;
        n = 0;
        while ((w16 ? (q16.size() != 0 || pend16) : (q8.size() != 0 || pend8)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (w16 ? (q16.size() != 0 || pend16) : (q8.size() != 0 || pend8)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done%0d: no completion within %0d cycles", w16 ? 16 : 8, budget);
            if (w16) begin q16.delete(); pend16 = 1'b0; end
            else begin q8.delete(); pend8 = 1'b0; end
        end
    endtask

    // Monitor for the 8-bit instance: pop on done, check results one cycle later.
    initial forever begin
        @(negedge clk);
        if (!rstb8) begin
            pend8 = 1'b0; pdone8 = 1'b0;
        end else begin
            if (pend8) begin
                check("c8_result", c8, pe8.c);
                check("err8_flag", err8, pe8.err);
                check("eoc8_set", eoc8, 1);
                check("busy8_released", busy8, 0);
                pend8 = 1'b0;
            end
            if (done8) begin
                check("done8_single_cycle", pdone8, 0);
                if (q8.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL done8_unexpected: done seen at cycle %0d, expected none", cnt);
                end else begin
                    pe8 = q8.pop_front();
                    check("done8_cycle", cnt, pe8.cyc);
                    pend8 = 1'b1;
                end
            end
            pdone8 = done8;
        end
    end

    // Monitor for the 16-bit instance.
    initial forever begin
        @(negedge clk);
        if (!rstb16) begin
            pend16 = 1'b0; pdone16 = 1'b0;
        end else begin
            if (pend16) begin
                check("c16_result", c16, pe16.c);
                check("err16_flag", err16, pe16.err);
                check("eoc16_set", eoc16, 1);
                check("busy16_released", busy16, 0);
                pend16 = 1'b0;
            end
            if (done16) begin
                check("done16_single_cycle", pdone16, 0);
                if (q16.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL done16_unexpected: done seen at cycle %0d, expected none", cnt);
                end else begin
                    pe16 = q16.pop_front();
                    check("done16_cycle", cnt, pe16.cyc);
                    pend16 = 1'b1;
                end
            end
            pdone16 = done16;
        end
    end

    task automatic directed8();
        run(1'b0, 16'd187, 16'd88, 16'd86, 16'd7, 1'b1, 0);
        wait_idle(1'b0, 400);
        run(1'b0, 16'd187, 16'd11, 16'd86, 16'd23, 1'b1, 0);
        wait_idle(1'b0, 400);
        run(1'b0, 16'd187, 16'd88, 16'd86, 16'd0, 1'b1, 0);
        wait_idle(1'b0, 400);
        run(1'b0, 16'd186, 16'd88, 16'd86, 16'd7, 1'b1, 0);
        wait_idle(1'b0, 400);
        // Abort in cycle 40, then restart immediately.
        run(1'b0, 16'd187, 16'd88, 16'd86, 16'd7, 1'b0, 0);
        repeat (39) @(negedge clk);
        stop8 = 1'b1;
        @(negedge clk);
        stop8 = 1'b0;
        check("busy8_after_stop", busy8, 0);
        check("eoc8_after_stop", eoc8, 0);
        check("c8_after_stop", c8, last_c8);
        run(1'b0, 16'd187, 16'd88, 16'd86, 16'd7, 1'b1, 0);
        wait_idle(1'b0, 400);
        // start and stop together in IDLE must not launch a run.
        start8 = 1'b1; stop8 = 1'b1;
        @(negedge clk);
        check("busy8_start_and_stop", busy8, 0);
        start8 = 1'b0; stop8 = 1'b0;
        // A start pulse mid-run is ignored.
        run(1'b0, 16'd187, 16'd88, 16'd86, 16'd7, 1'b1, 0);
        repeat (49) @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_idle(1'b0, 400);
        // ena low for five cycles stretches the run by five.
        run(1'b0, 16'd187, 16'd11, 16'd86, 16'd23, 1'b1, 5);
        repeat (20) @(negedge clk);
        ena8 = 1'b0;
        repeat (5) @(negedge clk);
        ena8 = 1'b1;
        wait_idle(1'b0, 400);
        // Asynchronous reset mid-run.
        run(1'b0, 16'd187, 16'd88, 16'd86, 16'd7, 1'b0, 0);
        repeat (30) @(negedge clk);
        #1 rstb8 = 1'b0;
        #1;
        check("c8_async_reset", c8, 0);
        check("eoc8_async_reset", eoc8, 0);
        check("busy8_async_reset", busy8, 0);
        last_c8 = 0;
        @(negedge clk);
        rstb8 = 1'b1;
        // Synchronous clear after a completed run.
        run(1'b0, 16'd187, 16'd88, 16'd86, 16'd7, 1'b1, 0);
        wait_idle(1'b0, 400);
        clear8 = 1'b1;
        @(negedge clk);
        clear8 = 1'b0;
        check("c8_clear", c8, 0);
        check("eoc8_clear", eoc8, 0);
        last_c8 = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic sweep16();
        logic [15:0] p, m, e, k;
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 4) p = 16'($urandom_range(1, 32767) * 2);
            else            p = 16'($urandom_range(1, 32767) * 2 + 1);
            m = 16'($urandom_range(0, int'(p) - 1));
            if (i == 0)      e = 16'h0000;
            else if (i == 1) e = 16'hFFFF;
            else             e = 16'($urandom_range(0, 65535));
            k = 16'((64'd1 << 32) % longint'(p));
            run(1'b1, p, m, k, e, 1'b1, 0);
            wait_idle(1'b1, 1000);
        end
    endtask

    initial begin
        rstb8 = 1'b0; ena8 = 1'b1; clear8 = 1'b0; start8 = 1'b0; stop8 = 1'b0;
        p8 = 8'd0; e8 = 8'd0; m8 = 8'd0; k8 = 8'd0;
        rstb16 = 1'b0; ena16 = 1'b1; clear16 = 1'b0; start16 = 1'b0; stop16 = 1'b0;
        p16 = 16'd0; e16 = 16'd0; m16 = 16'd0; k16 = 16'd0;
        repeat (2) @(negedge clk);
        check("c8_reset", c8, 0);
        check("busy8_reset", busy8, 0);
        check("done8_reset", done8, 0);
        check("eoc8_reset", eoc8, 0);
        check("err8_reset", err8, 0);
        check("c16_reset", c16, 0);
        rstb8 = 1'b1;
        rstb16 = 1'b1;
        @(negedge clk);
        fork
            directed8();
            sweep16();
        join
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
